// File: rtl/mem_arb_pkg.sv
// Shared types and owner encodings for the two-port memory arbiter.
package mem_arb_pkg;

  typedef logic [1:0] owner_t;

  localparam owner_t PORT0      = 2'd0;
  localparam owner_t PORT1      = 2'd1;
  localparam owner_t OWNER_NONE = 2'd2;

  localparam int unsigned NUM_PORTS = 2;

endpackage

// File: rtl/arb_grant_select.sv
// Combinational grant pick: lock hold, then yield hand-off, then base policy.
// Base policy is round-robin when ARB_ROUND_ROBIN_EN is defined, else fixed priority to port 0.
module arb_grant_select
  import mem_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  owner_t               owner,
  input  logic                 hold_ok,
  input  logic                 yield,
  input  logic                 last,
  output logic [NUM_PORTS-1:0] sel
);

  always_comb begin
    sel = '0;
    if ((owner != OWNER_NONE) && req[owner[0]] && !yield && hold_ok) begin
      sel[owner[0]] = 1'b1;
    end else if (yield) begin
      // The port that just finished a full burst steps aside for one cycle.
      if (req[~last]) begin
        sel[~last] = 1'b1;
      end else if (req[last]) begin
        sel[last] = 1'b1;
      end
    end else begin
`ifdef ARB_ROUND_ROBIN_EN
      if (&req) begin
        sel[~last] = 1'b1;
      end else begin
        sel = req;
      end
`else
      if (req[0]) begin
        sel = 2'b01;
      end else begin
        sel = req;
      end
`endif
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous memory with burst locking.
// Define ARB_ROUND_ROBIN_EN for round-robin base policy; default is fixed priority to port 0.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 12,
  parameter int unsigned MAX_BURST     = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req0,
  input  logic                     req1,
  input  logic                     we0,
  input  logic                     we1,
  input  logic                     lock0,
  input  logic                     lock1,
  input  logic [ADDRESS_WIDTH-1:0] addr0,
  input  logic [ADDRESS_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0]    wdata0,
  input  logic [DATA_WIDTH-1:0]    wdata1,
  output logic                     gnt0,
  output logic                     gnt1,
  output logic                     rvalid0,
  output logic                     rvalid1,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic                     mem_wEn,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_dataIn,
  input  logic [DATA_WIDTH-1:0]    mem_dataOut
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  owner_t                 owner;
  logic [CNT_W-1:0]       burst_cnt;
  logic                   last;
  logic                   yield;
  logic [NUM_PORTS-1:0]   req;
  logic [NUM_PORTS-1:0]   sel;
  logic [NUM_PORTS-1:0]   gnt;
  logic                   hold_ok;
  logic                   gidx;
  logic                   glock;
  logic [CNT_W-1:0]       cnt_inc;

  assign req     = {req1, req0};
  assign hold_ok = (burst_cnt < CNT_W'(MAX_BURST));

  arb_grant_select u_sel (
    .req     (req),
    .owner   (owner),
    .hold_ok (hold_ok),
    .yield   (yield),
    .last    (last),
    .sel     (sel)
  );

  // No access is accepted while reset is held.
  assign gnt   = sel & {NUM_PORTS{~reset}};
  assign gnt0  = gnt[0];
  assign gnt1  = gnt[1];
  assign rdata = mem_dataOut;

  always_comb begin
    mem_wEn    = 1'b0;
    mem_addr   = '0;
    mem_dataIn = '0;
    if (gnt[0]) begin
      mem_wEn    = we0;
      mem_addr   = addr0;
      mem_dataIn = wdata0;
    end else if (gnt[1]) begin
      mem_wEn    = we1;
      mem_addr   = addr1;
      mem_dataIn = wdata1;
    end
  end

  // Burst count for the granted port: continue the running burst or start at 1.
  always_comb begin
    gidx    = gnt[1];
    glock   = gidx ? lock1 : lock0;
    cnt_inc = CNT_W'(1);
    if (owner == {1'b0, gidx}) begin
      cnt_inc = (burst_cnt == CNT_W'(MAX_BURST)) ? burst_cnt : burst_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner     <= OWNER_NONE;
      burst_cnt <= '0;
      last      <= 1'b1;
      yield     <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
    end else begin
      rvalid0   <= gnt[0] & ~we0;
      rvalid1   <= gnt[1] & ~we1;
      owner     <= OWNER_NONE;
      burst_cnt <= '0;
      yield     <= 1'b0;
      if (|gnt) begin
        last <= gidx;
        if (glock) begin
          if (cnt_inc == CNT_W'(MAX_BURST)) begin
            yield <= 1'b1;
          end else begin
            owner     <= owner_t'({1'b0, gidx});
            burst_cnt <= cnt_inc;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus random bench for mem_port_arbiter against a rule-level arbitration model.
module tb_mem_port_arbiter;

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 12;
  localparam int unsigned MAXB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    t_req, t_we, t_lock;
  logic [AW-1:0] t_addr  [2];
  logic [DW-1:0] t_wdata [2];
  logic          gnt0, gnt1, rvalid0, rvalid1, mem_wEn;
  logic [DW-1:0] rdata, mem_dataIn, mem_dataOut;
  logic [AW-1:0] mem_addr;

  logic          mem_clr, bd_we;
  logic [AW-1:0] bd_addr;
  logic [DW-1:0] bd_data;
  logic [DW-1:0] dut_mem [0:4095];
  logic [DW-1:0] ref_mem [0:4095];

  int n_assert = 0;
  int n_fail   = 0;

  int       m_owner, m_cnt, m_last;
  bit       m_yield;
  bit [1:0] m_rv;
  logic [DW-1:0] m_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MAX_BURST(MAXB)) dut (
    .clk(clk), .reset(reset),
    .req0(t_req[0]), .req1(t_req[1]), .we0(t_we[0]), .we1(t_we[1]),
    .lock0(t_lock[0]), .lock1(t_lock[1]), .addr0(t_addr[0]), .addr1(t_addr[1]),
    .wdata0(t_wdata[0]), .wdata1(t_wdata[1]), .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata), .mem_wEn(mem_wEn),
    .mem_addr(mem_addr), .mem_dataIn(mem_dataIn), .mem_dataOut(mem_dataOut)
  );

  // Single-port memory with registered read, plus a clear/backdoor path for the bench.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 4096; i++) dut_mem[i] <= '0;
    end else if (bd_we) begin
      dut_mem[bd_addr] <= bd_data;
    end else if (mem_wEn) begin
      dut_mem[mem_addr] <= mem_dataIn;
    end
    if (!mem_wEn) mem_dataOut <= dut_mem[mem_addr];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Winner from the arbitration rules: lock hold, yield hand-off, then base policy.
  function automatic int pick();
    if (m_owner >= 0 && t_req[m_owner] && !m_yield && m_cnt < int'(MAXB)) return m_owner;
    if (m_yield) begin
      if (t_req[1 - m_last]) return 1 - m_last;
      if (t_req[m_last]) return m_last;
      return -1;
    end
`ifdef ARB_ROUND_ROBIN_EN
    if (t_req == 2'b11) return 1 - m_last;
`endif
    if (t_req[0]) return 0;
    if (t_req[1]) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_cnt = 0; m_last = 1; m_yield = 0; m_rv = 2'b00;
  endtask

  task automatic set_port(input int p, input logic r, input logic w, input logic l,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    t_req[p] = r; t_we[p] = w; t_lock[p] = l; t_addr[p] = a; t_wdata[p] = d;
  endtask

  // One cycle: drive at negedge, check mid-low phase, advance model at posedge.
  task automatic step(input bit rst, input int want);
    int w;
    int n;
    logic [1:0] want_v;
    reset = rst;
    #1;
    w = rst ? -1 : pick();
    check("gnt0", 64'(gnt0), 64'(w == 0));
    check("gnt1", 64'(gnt1), 64'(w == 1));
    check("mem_wEn", 64'(mem_wEn), (w >= 0) ? 64'(t_we[w]) : 64'd0);
    check("mem_addr", 64'(mem_addr), (w >= 0) ? 64'(t_addr[w]) : 64'd0);
    if (w >= 0 && t_we[w]) check("mem_dataIn", 64'(mem_dataIn), 64'(t_wdata[w]));
    check("rvalid0", 64'(rvalid0), 64'(m_rv[0]));
    check("rvalid1", 64'(rvalid1), 64'(m_rv[1]));
    if (m_rv != 2'b00) check("rdata", 64'(rdata), 64'(m_rdata));
    if (want != -2) begin
      want_v = (want == 0) ? 2'b01 : (want == 1) ? 2'b10 : 2'b00;
      check("gnt_dir", 64'({gnt1, gnt0}), 64'(want_v));
    end
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      m_rv = 2'b00;
      m_yield = 0;
      if (w >= 0) begin
        if (t_we[w]) ref_mem[t_addr[w]] = t_wdata[w];
        else begin
          m_rv[w] = 1'b1;
          m_rdata = ref_mem[t_addr[w]];
        end
        m_last = w;
        if (t_lock[w]) begin
          n = (m_owner == w) ? m_cnt + 1 : 1;
          if (n >= int'(MAXB)) begin
            m_owner = -1; m_cnt = 0; m_yield = 1;
          end else begin
            m_owner = w; m_cnt = n;
          end
        end else begin
          m_owner = -1; m_cnt = 0;
        end
      end else begin
        m_owner = -1; m_cnt = 0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; mem_clr = 1'b1; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    set_port(0, 0, 0, 0, '0, '0);
    set_port(1, 0, 0, 0, '0, '0);
    for (int i = 0; i < 4096; i++) ref_mem[i] = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    mem_clr = 1'b0;

    // Reset held two cycles while port 0 is trying to read.
    set_port(0, 1, 0, 0, 12'h005, '0);
    step(1, -1);
    step(1, -1);
    set_port(0, 0, 0, 0, '0, '0);
    step(0, -1);
    check("rst_no_stale_rv0", 64'(rvalid0), 64'd0);

    // Single read of a preloaded word.
    bd_we = 1'b1; bd_addr = 12'h010; bd_data = 32'hDEADBEEF;
    ref_mem[12'h010] = 32'hDEADBEEF;
    step(0, -1);
    bd_we = 1'b0;
    set_port(0, 1, 0, 0, 12'h010, '0);
    step(0, 0);
    set_port(0, 0, 0, 0, '0, '0);
    check("t2_rvalid0", 64'(rvalid0), 64'd1);
    check("t2_rdata", 64'(rdata), 64'hDEADBEEF);
    check("t2_rvalid1", 64'(rvalid1), 64'd0);
    step(0, -1);

    // Both ports requesting every cycle without lock.
    step(1, -1);
    set_port(0, 1, 0, 0, 12'h001, '0);
    set_port(1, 1, 0, 0, 12'h002, '0);
`ifdef ARB_ROUND_ROBIN_EN
    step(0, 0); step(0, 1); step(0, 0); step(0, 1);
`else
    step(0, 0); step(0, 0); step(0, 0); step(0, 0);
`endif

    // Locked burst from port 0 capped at MAX_BURST, one turn for port 1, then relock.
    step(1, -1);
    set_port(0, 1, 0, 1, 12'h020, '0);
    set_port(1, 1, 0, 0, 12'h030, '0);
    step(0, 0); step(0, 0); step(0, 0); step(0, 0);
    step(0, 1);
    step(0, 0);

    // Write on port 1 then read back on port 0.
    set_port(0, 0, 0, 0, '0, '0);
    set_port(1, 1, 1, 0, 12'h3FF, 32'h12345678);
    step(0, 1);
    check("t5_no_rv_on_write", 64'({rvalid1, rvalid0}), 64'd0);
    set_port(1, 0, 0, 0, '0, '0);
    set_port(0, 1, 0, 0, 12'h3FF, '0);
    step(0, 0);
    set_port(0, 0, 0, 0, '0, '0);
    check("t5_rvalid0", 64'(rvalid0), 64'd1);
    check("t5_rdata", 64'(rdata), 64'h12345678);
    step(0, -1);

    // Owner goes idle for a cycle: ownership dropped, port 1 served.
    step(1, -1);
    set_port(0, 1, 0, 1, 12'h040, '0);
    step(0, 0);
    set_port(0, 0, 0, 1, 12'h040, '0);
    set_port(1, 1, 0, 0, 12'h050, '0);
    step(0, 1);
    set_port(1, 0, 0, 0, '0, '0);
    step(0, -1);

    // Random traffic with occasional reset.
    for (int k = 0; k < 300; k++) begin
      for (int p = 0; p < 2; p++) begin
        set_port(p, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 1) == 1), AW'($urandom_range(0, 15)), $urandom);
      end
      step(($urandom_range(0, 59) == 0), -2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
